// File: rtl/div_pkg.sv
// Shared definitions for the sequential 32-bit divider: FSM encoding, step
// count, operation latency and operand magnitude helper.
package div_pkg;

    localparam int DIV_W         = 32;
    localparam int SEQ_DIV_STEPS = 32;
    localparam int SEQ_DIV_LAT   = 33;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } div_state_e;

    // Magnitude of a 32-bit operand; only negated when the signed mode applies.
    function automatic logic [31:0] abs_val(input logic [31:0] v, input logic sgn);
        logic [31:0] r;
        if (sgn && v[31]) begin
            r = 32'd0 - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_div.sv
// Sequential restoring divider, 32 quotient bits MSB first, signed/unsigned.
// Optional SEQ_DIV_ZERO_FAST_EN: zero-divisor operations skip BUSY entirely.
module seq_div
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        div_signed,
    input  logic        s_axis_dividend_tvalid,
    output logic        s_axis_dividend_tready,
    input  logic [31:0] s_axis_dividend_tdata,
    input  logic        s_axis_divisor_tvalid,
    output logic        s_axis_divisor_tready,
    input  logic [31:0] s_axis_divisor_tdata,
    output logic        m_axis_dout_tvalid,
    output logic [63:0] m_axis_dout_tdata
);

    localparam logic [4:0] LAST_STEP = 5'(SEQ_DIV_STEPS - 1);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;     // shifts dividend bits out, quotient bits in
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] raw_q, raw_d;
    logic        zero_q, zero_d;
    logic        signed_q, signed_d;
    logic        q_sign_q, q_sign_d;
    logic        r_sign_q, r_sign_d;
    logic        tready_q, tready_d;
    logic        tvalid_q, tvalid_d;
    logic [63:0] dout_q, dout_d;

    logic        hs_s;
    logic [32:0] rem_sh_s;
    logic        ge_s;
    logic [31:0] rem_nx_s;
    logic [31:0] quo_nx_s;
    logic        q_neg_s;
    logic        r_neg_s;
    logic [31:0] q_fix_s;
    logic [31:0] r_fix_s;
    logic [63:0] result_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_sh_s = {rem_q, dvd_q[31]};
        ge_s     = (rem_sh_s >= {1'b0, dvs_q});
        if (ge_s) begin
            rem_nx_s = rem_sh_s[31:0] - dvs_q;
        end else begin
            rem_nx_s = rem_sh_s[31:0];
        end
        quo_nx_s = {dvd_q[30:0], ge_s};
    end

    // Sign fix-up of the final step result and the divide-by-zero override.
    always_comb begin
        q_neg_s = signed_q & q_sign_q;
        r_neg_s = signed_q & r_sign_q;
        if (q_neg_s) begin
            q_fix_s = 32'd0 - quo_nx_s;
        end else begin
            q_fix_s = quo_nx_s;
        end
        if (r_neg_s) begin
            r_fix_s = 32'd0 - rem_nx_s;
        end else begin
            r_fix_s = rem_nx_s;
        end
        if (zero_q) begin
            result_s = {32'hFFFF_FFFF, raw_q};
        end else begin
            result_s = {q_fix_s, r_fix_s};
        end
    end

    // Next-state and datapath update for the IDLE/BUSY/DONE controller.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        raw_d    = raw_q;
        zero_d   = zero_q;
        signed_d = signed_q;
        q_sign_d = q_sign_q;
        r_sign_d = r_sign_q;
        tvalid_d = 1'b0;
        dout_d   = dout_q;
        hs_s     = s_axis_dividend_tvalid & s_axis_divisor_tvalid;

        case (state_q)
            ST_IDLE: begin
                if (hs_s) begin
                    dvd_d    = abs_val(s_axis_dividend_tdata, div_signed);
                    dvs_d    = abs_val(s_axis_divisor_tdata, div_signed);
                    rem_d    = 32'd0;
                    cnt_d    = 5'd0;
                    raw_d    = s_axis_dividend_tdata;
                    zero_d   = (s_axis_divisor_tdata == 32'd0);
                    signed_d = div_signed;
                    q_sign_d = s_axis_dividend_tdata[31] ^ s_axis_divisor_tdata[31];
                    r_sign_d = s_axis_dividend_tdata[31];
                    state_d  = ST_BUSY;
`ifdef SEQ_DIV_ZERO_FAST_EN
                    if (s_axis_divisor_tdata == 32'd0) begin
                        state_d  = ST_DONE;
                        tvalid_d = 1'b1;
                        dout_d   = {32'hFFFF_FFFF, s_axis_dividend_tdata};
                    end else begin
                        state_d  = ST_BUSY;
                    end
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                rem_d = rem_nx_s;
                dvd_d = quo_nx_s;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_STEP) begin
                    state_d  = ST_DONE;
                    tvalid_d = 1'b1;
                    dout_d   = result_s;
                end else begin
                    state_d  = ST_BUSY;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tready_d = (state_d == ST_IDLE);
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            dvd_q    <= 32'd0;
            rem_q    <= 32'd0;
            dvs_q    <= 32'd0;
            raw_q    <= 32'd0;
            zero_q   <= 1'b0;
            signed_q <= 1'b0;
            q_sign_q <= 1'b0;
            r_sign_q <= 1'b0;
            tready_q <= 1'b1;
            tvalid_q <= 1'b0;
            dout_q   <= 64'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            raw_q    <= raw_d;
            zero_q   <= zero_d;
            signed_q <= signed_d;
            q_sign_q <= q_sign_d;
            r_sign_q <= r_sign_d;
            tready_q <= tready_d;
            tvalid_q <= tvalid_d;
            dout_q   <= dout_d;
        end
    end

    assign s_axis_dividend_tready = tready_q;
    assign s_axis_divisor_tready  = tready_q;
    assign m_axis_dout_tvalid     = tvalid_q;
    assign m_axis_dout_tdata      = dout_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: arithmetic reference model plus
// directed cases and randomized handshakes.
module tb_seq_div;
    import div_pkg::*;

`ifdef SEQ_DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = SEQ_DIV_LAT;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        div_signed;
    logic        a_valid, b_valid;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, o_valid;
    logic [63:0] o_data;

    int checks = 0;
    int failures = 0;

    int          cyc = 0;
    int          m_left = 0;
    bit          m_valid = 1'b0;
    logic [63:0] m_res = 64'd0;
    logic [63:0] exp_dout = 64'd0;
    int          hs_cnt = 0;
    int          hs_edge = 0;

    seq_div dut (
        .clk                    (clk),
        .reset                  (reset),
        .div_signed             (div_signed),
        .s_axis_dividend_tvalid (a_valid),
        .s_axis_dividend_tready (a_ready),
        .s_axis_dividend_tdata  (a_data),
        .s_axis_divisor_tvalid  (b_valid),
        .s_axis_divisor_tready  (b_ready),
        .s_axis_divisor_tdata   (b_data),
        .m_axis_dout_tvalid     (o_valid),
        .m_axis_dout_tdata      (o_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {q[31:0], r[31:0]};
    endfunction

    function automatic logic [31:0] rnd32();
        int k;
        k = $urandom_range(0, 7);
        case (k)
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: handshake when idle, result visible LAT cycles later.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_left   = 0;
                m_valid  = 1'b0;
                exp_dout = 64'd0;
            end else begin
                cyc++;
                if (m_valid) begin
                    m_valid = 1'b0;
                end else if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_valid  = 1'b1;
                        exp_dout = m_res;
                    end
                end else if (a_valid && b_valid) begin
                    m_res   = ref_div(a_data, b_data, div_signed);
                    hs_cnt++;
                    hs_edge = cyc;
                    m_left  = ((b_data == 32'd0) ? ZLAT : SEQ_DIV_LAT) - 1;
                    if (m_left == 0) begin
                        m_valid  = 1'b1;
                        exp_dout = m_res;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("tvalid", {63'd0, o_valid}, {63'd0, m_valid});
            chk("dividend_tready", {63'd0, a_ready}, {63'd0, (!m_valid && m_left == 0)});
            chk("divisor_tready", {63'd0, b_ready}, {63'd0, (!m_valid && m_left == 0)});
            chk("tdata", o_data, exp_dout);
        end
    end

    task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [63:0] exp, input string nm, input int lat);
        int h0, t, e0;
        h0 = hs_cnt;
        a_data = a; b_data = b; div_signed = s;
        a_valid = 1'b1; b_valid = 1'b1;
        t = 0;
        while (hs_cnt == h0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        a_valid = 1'b0; b_valid = 1'b0; div_signed = ~s;
        if (hs_cnt == h0) begin
            checks++;
            failures++;
            $display("FAIL %s_handshake: no handshake within 200 cycles", nm);
            return;
        end
        e0 = hs_edge;
        t = 0;
        while (o_valid !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_dout"}, o_data, exp);
        chk({nm, "_latency"}, 64'(cyc - e0 + 1), 64'(lat));
        @(negedge clk);
    endtask

    initial begin
        int h0, e1, t;
        reset = 1'b1; div_signed = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; a_data = 32'd0; b_data = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_tready", {62'd0, a_ready, b_ready}, 64'd3);
        chk("reset_dout", o_data, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        chk("model_u100_7", ref_div(32'd100, 32'd7, 1'b0), 64'h0000000E_00000002);
        chk("model_s_m7_2", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), 64'hFFFFFFFD_FFFFFFFF);
        chk("model_ovf", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), 64'h80000000_00000000);

        op(32'd100, 32'd7, 1'b0, 64'h0000000E_00000002, "u100_7", SEQ_DIV_LAT);
        op(32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFFFFFD_FFFFFFFF, "s_m7_2", SEQ_DIV_LAT);
        op(32'd7, 32'hFFFF_FFFE, 1'b1, 64'hFFFFFFFD_00000001, "s_7_m2", SEQ_DIV_LAT);
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h80000000_00000000, "s_ovf", SEQ_DIV_LAT);
        op(32'hFFFF_FFFF, 32'd1, 1'b0, 64'hFFFFFFFF_00000000, "u_max_1", SEQ_DIV_LAT);
        op(32'd5, 32'd0, 1'b0, 64'hFFFFFFFF_00000005, "u_5_0", ZLAT);
        op(32'hFFFF_FFF0, 32'd0, 1'b1, 64'hFFFFFFFF_FFFFFFF0, "s_neg_0", ZLAT);

        // Single-sided offers must not start an operation.
        a_data = 32'd50; b_data = 32'd5;
        a_valid = 1'b1; repeat (4) @(negedge clk); a_valid = 1'b0;
        b_valid = 1'b1; repeat (4) @(negedge clk); b_valid = 1'b0;
        @(negedge clk);

        // Reset in the middle of BUSY.
        h0 = hs_cnt;
        a_data = 32'd200; b_data = 32'd3; div_signed = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        t = 0;
        while (hs_cnt == h0 && t < 50) begin @(negedge clk); t++; end
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midbusy_reset_tready", {62'd0, a_ready, b_ready}, 64'd3);
        chk("midbusy_reset_tvalid", {63'd0, o_valid}, 64'd0);
        chk("midbusy_reset_dout", o_data, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        op(32'd9, 32'd3, 1'b0, 64'h00000003_00000000, "after_reset_9_3", SEQ_DIV_LAT);

        // Back-to-back: second pair held valid from cycle 1.
        h0 = hs_cnt;
        a_data = 32'd100; b_data = 32'd7; div_signed = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        t = 0;
        while (hs_cnt == h0 && t < 50) begin @(negedge clk); t++; end
        e1 = hs_edge;
        a_data = 32'd9; b_data = 32'd3;
        t = 0;
        while (hs_cnt == h0 + 1 && t < 100) begin @(negedge clk); t++; end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("b2b_accept_cycle", 64'(hs_edge - e1), 64'd34);
        t = 0;
        while (o_valid !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        chk("b2b_result_cycle", 64'(cyc - e1 + 1), 64'd67);
        chk("b2b_result", o_data, 64'h00000003_00000000);

        // Randomized traffic, including offers during BUSY and DONE.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            a_valid    = ($urandom_range(0, 3) != 0);
            b_valid    = ($urandom_range(0, 3) != 0);
            a_data     = rnd32();
            b_data     = rnd32();
            div_signed = 1'($urandom_range(0, 1));
        end
        a_valid = 1'b0; b_valid = 1'b0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
